// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the IMEM loader.
//   BYTE_W      stream byte width
//   ADDR_W_DEF  default IMEM word-address width
//   DATA_W_DEF  default instruction width
//   ldr_state_t loader FSM state encoding
package imem_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} ldr_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: collects a little-endian byte stream into one instruction word.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       restart assembly at byte 0
//   byte_stb    byte_in is consumed this cycle
//   byte_in     stream byte; byte k lands in bits [8k+7:8k]
//   word        assembled word (holds until the next byte is inserted)
//   word_full   this strobe delivers the final byte of the word
module imem_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_stb,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    localparam int unsigned BYTES = DATA_W / BYTE_W;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] word_q, word_d;

    assign word_full = byte_stb && (byte_idx_q == IDX_W'(BYTES - 1));
    assign word      = word_q;

    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        if (clear) begin
            byte_idx_d = '0;
        end else if (byte_stb) begin
            word_d[byte_idx_q*BYTE_W +: BYTE_W] = byte_in;
            // Explicit wrap so non-power-of-two byte counts also restart at 0.
            byte_idx_d = word_full ? '0 : byte_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream before the core runs.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing checksum byte, load_err).
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   load_start, load_len  start request (IDLE only); word count, 0 means 2**ADDR_W
//   rx_data, rx_valid     byte stream in; rx_ready out, transfer = rx_valid & rx_ready
//   imem_we/addr/wdata    one-cycle IMEM word write; addr/wdata hold between writes
//   cpu_hold, load_busy   high whenever the FSM is not IDLE
//   load_done             one-cycle pulse at end of load
//   load_err              checksum mismatch (0 when the checksum feature is off)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    ldr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;

    logic              rx_xfer;
    logic              byte_stb;
    logic              start_acc;
    logic              asm_full;
    logic [DATA_W-1:0] asm_word;

    assign rx_xfer   = rx_valid & rx_ready;
    assign byte_stb  = rx_xfer && (state_q == RECV);
    assign start_acc = (state_q == IDLE) && load_start;

    imem_word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_acc || (state_q == WRITE)),
        .byte_stb  (byte_stb),
        .byte_in   (rx_data),
        .word      (asm_word),
        .word_full (asm_full)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (load_start) state_d = RECV;
            RECV:  if (asm_full) state_d = WRITE;
            WRITE: begin
                if (word_cnt_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:   if (rx_xfer) state_d = DONE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        rx_ready  = 1'b0;
        imem_we   = 1'b0;
        load_done = 1'b0;
        unique case (state_q)
            RECV:  rx_ready = 1'b1;
            WRITE: imem_we = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:   rx_ready = 1'b1;
`endif
            DONE:  load_done = 1'b1;
            default: ;
        endcase
    end

    assign load_busy  = (state_q != IDLE);
    assign cpu_hold   = load_busy;
    // Live values during WRITE, captured copies otherwise so the bus holds between writes.
    assign imem_addr  = imem_we ? word_cnt_q : addr_hold_q;
    assign imem_wdata = imem_we ? asm_word : wdata_hold_q;

    always_comb begin
        last_d       = last_q;
        word_cnt_d   = word_cnt_q;
        addr_hold_d  = addr_hold_q;
        wdata_hold_d = wdata_hold_q;
        if (start_acc) begin
            // load_len of 0 wraps to all-ones, i.e. a full 2**ADDR_W image.
            last_d     = load_len - 1'b1;
            word_cnt_d = '0;
        end
        if (state_q == WRITE) begin
            addr_hold_d  = word_cnt_q;
            wdata_hold_d = asm_word;
            // Stop at last so the counter never wraps back onto address 0.
            if (word_cnt_q != last_q) word_cnt_d = word_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q       <= '0;
            word_cnt_q   <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            last_q       <= last_d;
            word_cnt_q   <= word_cnt_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;

    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (start_acc) begin
            sum_d = '0;
            err_d = 1'b0;
        end else if (byte_stb) begin
            sum_d = sum_q + rx_data;
        end else if ((state_q == CHK) && rx_xfer) begin
            err_d = ((sum_q + rx_data) != 8'h00);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven bench for imem_loader.
// Exercises the IMEM_LOADER_CHECKSUM_EN paths when that macro is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  load_len = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    imem_loader #(
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] run_sum = '0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t  wr_q[$];
    logic prev_we = 1'b0;

    typedef struct {
        int          len;
        logic [7:0]  b[12];
        logic [31:0] exp[3];
        bit          gaps;
        bit          idle_noise;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: records every IMEM write and checks per-write invariants.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_t w;
            w.addr = imem_addr;
            w.data = imem_wdata;
            wr_q.push_back(w);
            check("rx_ready low in WRITE", 32'(rx_ready), 32'd0);
            check("cpu_hold high in WRITE", 32'(cpu_hold), 32'd1);
            check("no back-to-back imem_we", 32'(prev_we), 32'd0);
        end
        prev_we <= imem_we;
    end

    task automatic start_load(input logic [7:0] len);
        @(negedge clk);
        load_start = 1'b1;
        load_len   = len;
        rx_valid   = 1'b0;
        run_sum    = '0;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_ready timeout: got 0, expected 1");
        end
        @(negedge clk);
        rx_valid = 1'b0;
        run_sum  = run_sum + b;
    endtask

    task automatic send_good_chk();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(~run_sum + 8'd1, 0);
`endif
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!load_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("load_done seen", 32'(load_done), 32'd1);
        @(negedge clk);
        check("load_done one cycle", 32'(load_done), 32'd0);
        check("cpu_hold dropped", 32'(cpu_hold), 32'd0);
        check("load_busy dropped", 32'(load_busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int bc;
        logic was_ready;

        vecs[0].len = 1;
        vecs[0].b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0].exp = '{32'h00000013, 32'h0, 32'h0};
        vecs[0].gaps = 1'b0;
        vecs[0].idle_noise = 1'b0;
        vecs[1].len = 3;
        vecs[1].b = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01,
                      8'h20, 8'h00, 8'hb3, 8'h01, 8'h21, 8'h00};
        vecs[1].exp = '{32'h00100093, 32'h00200113, 32'h002101b3};
        vecs[1].gaps = 1'b1;
        vecs[1].idle_noise = 1'b0;
        vecs[2].len = 2;
        vecs[2].b = '{8'hef, 8'hbe, 8'had, 8'hde, 8'h78, 8'h56,
                      8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].exp = '{32'hdeadbeef, 32'h12345678, 32'h0};
        vecs[2].gaps = 1'b0;
        vecs[2].idle_noise = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset rx_ready", 32'(rx_ready), 32'd0);
        check("reset imem_we", 32'(imem_we), 32'd0);
        check("reset imem_addr", 32'(imem_addr), 32'd0);
        check("reset imem_wdata", imem_wdata, 32'd0);
        check("reset cpu_hold", 32'(cpu_hold), 32'd0);
        check("reset load_busy", 32'(load_busy), 32'd0);
        check("reset load_done", 32'(load_done), 32'd0);
        check("reset load_err", 32'(load_err), 32'd0);
        reset = 1'b0;

        // Table-driven loads
        for (int v = 0; v < 3; v++) begin
            wr_q.delete();
            if (vecs[v].idle_noise) begin
                rx_data  = 8'haa;
                rx_valid = 1'b1;
                repeat (3) @(negedge clk);
                check("rx_ready low in IDLE", 32'(rx_ready), 32'd0);
            end
            start_load(8'(vecs[v].len));
            check("cpu_hold after start", 32'(cpu_hold), 32'd1);
            check("load_busy after start", 32'(load_busy), 32'd1);
            for (int k = 0; k < 4 * vecs[v].len; k++) begin
                send_byte(vecs[v].b[k], vecs[v].gaps ? int'($urandom_range(0, 3)) : 0);
            end
            send_good_chk();
            wait_done();
            check("vec write count", 32'(wr_q.size()), 32'(vecs[v].len));
            for (int i = 0; i < vecs[v].len; i++) begin
                if (i < wr_q.size()) begin
                    check("vec addr", 32'(wr_q[i].addr), 32'(i));
                    check("vec data", wr_q[i].data, vecs[v].exp[i]);
                end
            end
            check("addr holds", 32'(imem_addr), 32'(vecs[v].len - 1));
            check("wdata holds", imem_wdata, vecs[v].exp[vecs[v].len - 1]);
            check("load_err clean", 32'(load_err), 32'd0);
        end

        // Full 256-word image with rx_valid held high
        wr_q.delete();
        start_load(8'd0);
        cyc = 0;
        bc = 0;
        rx_data = 8'h00;
        rx_valid = 1'b1;
        while (!load_done && cyc < 2000) begin
            was_ready = rx_ready;
            @(negedge clk);
            cyc++;
            if (was_ready) begin
                bc++;
                rx_data = 8'(bc);
            end
        end
        rx_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("len0 done latency", 32'(cyc), 32'd1281);
        check("len0 bytes consumed", 32'(bc), 32'd1025);
        check("len0 load_err", 32'(load_err), 32'd0);
`else
        check("len0 done latency", 32'(cyc), 32'd1280);
        check("len0 bytes consumed", 32'(bc), 32'd1024);
`endif
        check("len0 write count", 32'(wr_q.size()), 32'd256);
        for (int i = 0; i < 256; i++) begin
            if (i < wr_q.size()) begin
                check("len0 addr", 32'(wr_q[i].addr), 32'(i));
                check("len0 data", wr_q[i].data,
                      {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
            end
        end
        @(negedge clk);
        check("len0 idle after", 32'(load_busy), 32'd0);

        // Reset in the middle of word 1
        wr_q.delete();
        start_load(8'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'haa, 0);
        send_byte(8'hbb, 0);
        reset = 1'b1;
        #1;
        check("mid reset imem_we", 32'(imem_we), 32'd0);
        check("mid reset rx_ready", 32'(rx_ready), 32'd0);
        check("mid reset cpu_hold", 32'(cpu_hold), 32'd0);
        check("mid reset load_busy", 32'(load_busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("mid reset write count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) begin
            check("mid reset addr", 32'(wr_q[0].addr), 32'd0);
            check("mid reset data", wr_q[0].data, 32'h04030201);
        end
        wr_q.delete();
        start_load(8'd1);
        send_byte(8'h37, 0);
        send_byte(8'h12, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_good_chk();
        wait_done();
        check("post reset write count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) begin
            check("post reset addr", 32'(wr_q[0].addr), 32'd0);
            check("post reset data", wr_q[0].data, 32'h00001237);
        end

        // load_start during RECV is ignored
        wr_q.delete();
        start_load(8'd2);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        load_start = 1'b1;
        load_len   = 8'd5;
        @(negedge clk);
        load_start = 1'b0;
        check("stray start busy", 32'(load_busy), 32'd1);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        send_good_chk();
        wait_done();
        check("stray start write count", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() >= 2) begin
            check("stray start addr0", 32'(wr_q[0].addr), 32'd0);
            check("stray start data0", wr_q[0].data, 32'h00100093);
            check("stray start addr1", 32'(wr_q[1].addr), 32'd1);
            check("stray start data1", wr_q[1].data, 32'h00200113);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good, then bad, then cleared by the next accepted start
        start_load(8'd1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'hed, 0);
        wait_done();
        check("chk ED load_err", 32'(load_err), 32'd0);
        start_load(8'd1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done();
        check("chk 00 load_err", 32'(load_err), 32'd1);
        repeat (3) @(negedge clk);
        check("chk 00 load_err held", 32'(load_err), 32'd1);
        start_load(8'd1);
        check("load_err cleared by start", 32'(load_err), 32'd0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'hed, 0);
        wait_done();
        check("chk final load_err", 32'(load_err), 32'd0);
`else
        check("load_err tied low", 32'(load_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
